// File: rtl/stream_arb_mux.sv
// Registered N-channel valid/ready stream arbiter-multiplexer. A grant is held
// for a whole packet (through the i_last beat). The selected beat is registered into a single output slot.
module stream_arb_mux #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int RR       = 1,
    parameter int CW       = $clog2(CHANNELS)
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [0:CHANNELS-1]       i_valid,
    input  logic [0:CHANNELS-1]       i_last,
    input  logic [0:CHANNELS*WIDTH-1] i_data,
    output logic [0:CHANNELS-1]       o_ready,
    output logic                      o_valid,
    output logic [0:WIDTH-1]          o_data,
    output logic                      o_last,
    output logic [0:CW-1]             o_chan,
    input  logic                      i_ready
);

    typedef enum logic {ST_UNLOCKED, ST_LOCKED} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     lock_chan_q, lock_chan_d;
    logic [CW-1:0]     ptr_q, ptr_d;
    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic              out_last_q, out_last_d;
    logic [CW-1:0]     out_chan_q, out_chan_d;

    logic              load_en;
    logic              arb_found;
    logic [CW-1:0]     arb_idx;
    logic [CW-1:0]     grant_idx;
    logic              grant_ok;
    logic              xfer;
    logic [WIDTH-1:0]  sel_data;

    // Search order: ptr, ptr+1, ... in round-robin mode, plain index order otherwise.
    function automatic int cand_of(input int p, input int i);
        if (RR != 0)
            return (p + i) % CHANNELS;
        else
            return i;
    endfunction

    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (!arb_found && i_valid[cand_of(int'(ptr_q), i)]) begin
                arb_found = 1'b1;
                arb_idx   = CW'(cand_of(int'(ptr_q), i));
            end
        end
    end

    assign load_en   = !out_valid_q || i_ready;
    assign grant_idx = (state_q == ST_LOCKED) ? lock_chan_q : arb_idx;
    assign grant_ok  = (state_q == ST_LOCKED) ? i_valid[grant_idx] : arb_found;
    // Reset gating keeps every o_ready low while i_rst_n is held, even though load_en is 1.
    assign xfer      = i_rst_n && load_en && grant_ok;
    assign sel_data  = i_data[int'(grant_idx)*WIDTH +: WIDTH];

    always_comb begin
        o_ready = '0;
        if (xfer)
            o_ready[grant_idx] = 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        lock_chan_d = lock_chan_q;
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_chan_d  = out_chan_q;
        if (load_en)
            out_valid_d = xfer;
        if (xfer) begin
            out_data_d = sel_data;
            out_last_d = i_last[grant_idx];
            out_chan_d = grant_idx;
            if (i_last[grant_idx]) begin
                state_d = ST_UNLOCKED;
                if (RR != 0) begin
                    if (int'(grant_idx) == CHANNELS - 1)
                        ptr_d = '0;
                    else
                        ptr_d = grant_idx + 1'b1;
                end
            end else begin
                state_d     = ST_LOCKED;
                lock_chan_d = grant_idx;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_UNLOCKED;
            lock_chan_q <= '0;
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_chan_q  <= '0;
        end else begin
            state_q     <= state_d;
            lock_chan_q <= lock_chan_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_chan_q  <= out_chan_d;
        end
    end

    assign o_valid = out_valid_q;
    assign o_data  = out_data_q;
    assign o_last  = out_last_q;
    assign o_chan  = out_chan_q;

endmodule

// File: tb/tb_stream_arb_mux.sv
// Directed bench for stream_arb_mux: three instances cover round-robin (4x16),
// fixed priority (4x16) and a 3-channel 8-bit round-robin wrap case.
module tb_stream_arb_mux;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A: RR=1, CHANNELS=4, WIDTH=16
    logic [0:3]  a_ival, a_ilast, a_ordy;
    logic [0:63] a_idata;
    logic        a_ov, a_ol, a_irdy;
    logic [0:15] a_od;
    logic [0:1]  a_oc;
    // Instance B: RR=0, CHANNELS=4, WIDTH=16
    logic [0:3]  b_ival, b_ilast, b_ordy;
    logic [0:63] b_idata;
    logic        b_ov, b_ol, b_irdy;
    logic [0:15] b_od;
    logic [0:1]  b_oc;
    // Instance C: RR=1, CHANNELS=3, WIDTH=8
    logic [0:2]  c_ival, c_ilast, c_ordy;
    logic [0:23] c_idata;
    logic        c_ov, c_ol, c_irdy;
    logic [0:7]  c_od;
    logic [0:1]  c_oc;

    stream_arb_mux #(.WIDTH(16), .CHANNELS(4), .RR(1)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(a_ival), .i_last(a_ilast),
        .i_data(a_idata), .o_ready(a_ordy), .o_valid(a_ov), .o_data(a_od),
        .o_last(a_ol), .o_chan(a_oc), .i_ready(a_irdy));

    stream_arb_mux #(.WIDTH(16), .CHANNELS(4), .RR(0)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(b_ival), .i_last(b_ilast),
        .i_data(b_idata), .o_ready(b_ordy), .o_valid(b_ov), .o_data(b_od),
        .o_last(b_ol), .o_chan(b_oc), .i_ready(b_irdy));

    stream_arb_mux #(.WIDTH(8), .CHANNELS(3), .RR(1)) u_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(c_ival), .i_last(c_ilast),
        .i_data(c_idata), .o_ready(c_ordy), .o_valid(c_ov), .o_data(c_od),
        .o_last(c_ol), .o_chan(c_oc), .i_ready(c_irdy));

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end else begin
            $display("vec %0d %s: %0h ok", n_vec, tag, obs);
        end
    endtask

    // Channel k's ready bit sits at index k of an ascending [0:N-1] vector.
    function automatic logic [3:0] oh4(input int k);
        return 4'b1000 >> k;
    endfunction
    function automatic logic [2:0] oh3(input int k);
        return 3'b100 >> k;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic v, input logic [15:0] d,
                         input logic l, input logic [1:0] c);
        chk({tag, "_valid"}, 32'(a_ov), 32'(v));
        chk({tag, "_data"},  32'(a_od), 32'(d));
        chk({tag, "_last"},  32'(a_ol), 32'(l));
        chk({tag, "_chan"},  32'(a_oc), 32'(c));
    endtask

    initial begin
        a_ival = '0; a_ilast = '0; a_idata = '0; a_irdy = 1'b1;
        b_ival = '0; b_ilast = '0; b_idata = '0; b_irdy = 1'b1;
        c_ival = '0; c_ilast = '0; c_idata = '0; c_irdy = 1'b1;

        // ---- Reset and idle ----
        #2;
        chk_a("rst0", 1'b0, 16'h0, 1'b0, 2'd0);
        cyc(); cyc();
        rst_n = 1'b1;
        a_ival[2] = 1'b1; a_ilast[2] = 1'b0; a_idata[32 +: 16] = 16'h2AAA;
        #1 chk("rst_p_rdy1", 32'(a_ordy), 32'(oh4(2)));
        cyc();
        chk_a("rst_p_b1", 1'b1, 16'h2AAA, 1'b0, 2'd2);
        a_idata[32 +: 16] = 16'h2BBB;
        cyc();
        chk_a("rst_p_b2", 1'b1, 16'h2BBB, 1'b0, 2'd2);
        rst_n = 1'b0;
        a_ival[2] = 1'b0;
        a_ival[0] = 1'b1; a_ilast[0] = 1'b1; a_idata[0 +: 16] = 16'h1111;
        #1;
        chk_a("rst_mid", 1'b0, 16'h0, 1'b0, 2'd0);
        chk("rst_mid_rdy", 32'(a_ordy), 32'h0);
        cyc();
        rst_n = 1'b1;
        #1 chk("rst_rel_rdy", 32'(a_ordy), 32'(oh4(0)));
        cyc();
        chk_a("rst_rel_out", 1'b1, 16'h1111, 1'b1, 2'd0);
        a_ival = '0;
        cyc();
        chk("rst_drain_valid", 32'(a_ov), 32'h0);

        // ---- Round-robin fairness (fresh pointer) ----
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) a_idata[k*16 +: 16] = 16'hA000 + 16'(k);
        a_ival = 4'b1111; a_ilast = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            #1 chk($sformatf("rr_rdy%0d", i), 32'(a_ordy), 32'(oh4(i % 4)));
            cyc();
            chk_a($sformatf("rr_out%0d", i), 1'b1, 16'hA000 + 16'(i % 4), 1'b1, 2'(i % 4));
        end
        a_ival = '0;
        cyc();

        // ---- Fixed priority ----
        b_ival[1] = 1'b1; b_ilast[1] = 1'b1; b_idata[16 +: 16] = 16'hB001;
        b_ival[3] = 1'b1; b_ilast[3] = 1'b1; b_idata[48 +: 16] = 16'hB003;
        for (int i = 0; i < 3; i++) begin
            #1 chk($sformatf("fp_rdy%0d", i), 32'(b_ordy), 32'(oh4(1)));
            cyc();
            chk($sformatf("fp_chan%0d", i), 32'(b_oc), 32'd1);
            chk($sformatf("fp_data%0d", i), 32'(b_od), 32'hB001);
        end
        b_ival[1] = 1'b0;
        #1 chk("fp_rdy3", 32'(b_ordy), 32'(oh4(3)));
        cyc();
        chk("fp_chan3", 32'(b_oc), 32'd3);
        chk("fp_data3", 32'(b_od), 32'hB003);
        b_ival = '0;
        cyc();

        // ---- Packet lock (pointer 0 -> 2 via a ch1 beat first) ----
        a_ival[1] = 1'b1; a_ilast[1] = 1'b1; a_idata[16 +: 16] = 16'h1001;
        #1 chk("lk_pre_rdy", 32'(a_ordy), 32'(oh4(1)));
        cyc();
        chk_a("lk_pre", 1'b1, 16'h1001, 1'b1, 2'd1);
        a_ival = '0;
        a_ival[0] = 1'b1; a_ilast[0] = 1'b1; a_idata[0 +: 16] = 16'h0C0C;
        a_ival[2] = 1'b1; a_ilast[2] = 1'b0; a_idata[32 +: 16] = 16'h2001;
        #1 chk("lk_rdy1", 32'(a_ordy), 32'(oh4(2)));
        cyc();
        chk_a("lk_b1", 1'b1, 16'h2001, 1'b0, 2'd2);
        a_ival[2] = 1'b0;
        #1 chk("lk_idle_rdy1", 32'(a_ordy), 32'h0);
        cyc();
        chk("lk_idle_valid", 32'(a_ov), 32'h0);
        #1 chk("lk_idle_rdy2", 32'(a_ordy), 32'h0);
        cyc();
        a_ival[2] = 1'b1; a_idata[32 +: 16] = 16'h2002;
        #1 chk("lk_rdy2", 32'(a_ordy), 32'(oh4(2)));
        cyc();
        chk_a("lk_b2", 1'b1, 16'h2002, 1'b0, 2'd2);
        a_ilast[2] = 1'b1; a_idata[32 +: 16] = 16'h2003;
        #1 chk("lk_rdy3", 32'(a_ordy), 32'(oh4(2)));
        cyc();
        chk_a("lk_b3", 1'b1, 16'h2003, 1'b1, 2'd2);
        a_ival[2] = 1'b0;
        #1 chk("lk_ch0_rdy", 32'(a_ordy), 32'(oh4(0)));
        cyc();
        chk_a("lk_ch0", 1'b1, 16'h0C0C, 1'b1, 2'd0);
        a_ival = '0;
        cyc();

        // ---- Backpressure (pointer now 1) ----
        a_ival[1] = 1'b1; a_ilast[1] = 1'b1; a_idata[16 +: 16] = 16'h1234;
        a_ival[3] = 1'b1; a_ilast[3] = 1'b1; a_idata[48 +: 16] = 16'h3333;
        #1 chk("bp_rdy0", 32'(a_ordy), 32'(oh4(1)));
        cyc();
        a_irdy = 1'b0;
        a_ival[1] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("bp_rdy_hold%0d", i), 32'(a_ordy), 32'h0);
            chk_a($sformatf("bp_hold%0d", i), 1'b1, 16'h1234, 1'b1, 2'd1);
            cyc();
        end
        a_irdy = 1'b1;
        #1 chk("bp_rdy_rel", 32'(a_ordy), 32'(oh4(3)));
        cyc();
        chk_a("bp_next", 1'b1, 16'h3333, 1'b1, 2'd3);
        a_ival = '0;
        cyc();
        chk("bp_drain_valid", 32'(a_ov), 32'h0);

        // ---- Wrap and width (3 channels, 8 bits) ----
        c_ival[2] = 1'b1; c_ilast[2] = 1'b1; c_idata[16 +: 8] = 8'h22;
        #1 chk("wr_rdy2", 32'(c_ordy), 32'(oh3(2)));
        cyc();
        chk("wr_data2", 32'(c_od), 32'h22);
        chk("wr_chan2", 32'(c_oc), 32'd2);
        c_ival = '0;
        c_ival[0] = 1'b1; c_ilast[0] = 1'b1; c_idata[0 +: 8] = 8'h5A;
        c_ival[1] = 1'b1; c_ilast[1] = 1'b1; c_idata[8 +: 8] = 8'hC3;
        #1 chk("wr_rdy0", 32'(c_ordy), 32'(oh3(0)));
        cyc();
        chk("wr_data0", 32'(c_od), 32'h5A);
        chk("wr_chan0", 32'(c_oc), 32'd0);
        chk("wr_valid0", 32'(c_ov), 32'd1);
        c_ival = '0;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/stream_arb_mux.md
Name: stream_arb_mux

Overview:
- Parametrised, registered N-channel, WIDTH-bit stream multiplexer. It is the sequential successor to the combinational bit/word muxes.
- Arbitrates between CHANNELS valid/ready sources and holds a grant for the whole packet, up to and including the i_last beat.
- Drives one registered output stream. It sits between producer ports (register file, ALU and load/store result paths) and a shared consumer such as the writeback or bus interface.

Parameters:
- WIDTH, 16, data bits per channel.
- CHANNELS, 4, number of input channels; range 2..16.
- RR, 1, arbitration mode. 1 = round-robin; 0 = fixed priority, lowest index wins.
- CW, $clog2(CHANNELS), width of the channel-index output. Derived; do not override.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  reset, asynchronous assert, active-low.
- i_valid  input  [0:CHANNELS-1]  per-channel beat valid.
- i_last  input  [0:CHANNELS-1]  per-channel last-beat-of-packet flag.
- i_data  input  [0:CHANNELS*WIDTH-1]  channel k data at bits [k*WIDTH : k*WIDTH+WIDTH-1].
- o_ready  output  [0:CHANNELS-1]  per-channel accept; beat k transfers when i_valid[k] and o_ready[k] are both 1.
- o_valid  output  1  output beat valid (registered).
- o_data  output  [0:WIDTH-1]  output data (registered).
- o_last  output  1  output last flag (registered).
- o_chan  output  [0:CW-1]  source channel of the current output beat (registered).
- i_ready  input  1  downstream accept; output beat transfers when o_valid and i_ready are both 1.

Behaviour:
- Reset (i_rst_n=0, asynchronous):
  - o_valid=0, o_data=0, o_last=0, o_chan=0.
  - Round-robin pointer = 0; lock state = UNLOCKED.
  - o_ready=0 for all channels while reset is asserted.
  - Any in-flight packet is abandoned. After reset the block starts clean, with no lock held.
- Output stage:
  - A single register slot. It may load when empty or draining: load_en = !o_valid || i_ready.
  - o_ready[k] = load_en && (grant == k) && i_valid[k]. It is combinational from the grant and i_ready.
  - At most one o_ready bit is 1 in any cycle.
- Latency and throughput:
  - Latency is 1 cycle from input transfer to o_valid.
  - Sustained throughput is 1 beat/cycle while i_ready=1.
  - No combinational path from i_data to o_data.
- When a load occurs, o_valid holds its value if no beat is accepted and i_ready=0. If no beat is accepted but i_ready=1, o_valid drops to 0.
- Arbitration state machine:
  - UNLOCKED:
    - The grant is computed among valid channels.
    - RR=0: lowest index with i_valid set.
    - RR=1: first valid channel at or after the pointer, searching ptr, ptr+1, ... modulo CHANNELS.
    - On transfer with i_last=1: stay UNLOCKED.
    - On transfer with i_last=0: go to LOCKED, holding the granted index.
  - LOCKED:
    - The grant is fixed to the locked channel. Other channels see o_ready=0 even when the locked channel is idle (i_valid=0).
    - A transfer with i_last=1 returns the FSM to UNLOCKED.
- Pointer update (RR=1 only):
  - On a transfer with i_last=1 from channel g, ptr <= (g+1) mod CHANNELS. Wrap from CHANNELS-1 goes to 0.
  - The pointer is unchanged on non-last beats and idle cycles.
- Backpressure: while o_valid=1 and i_ready=0:
  - o_data, o_last and o_chan hold stable.
  - All o_ready are 0.
  - The lock and pointer do not change.
- Simultaneous events:
  - A drain (i_ready=1) and a new load in the same cycle are legal. The register takes the new beat and o_valid stays 1.
  - A last beat transfer and a new request from another channel in the same cycle: the new channel is granted no earlier than the next cycle.
- No valid input while unlocked: o_ready all 0; state unchanged.

Test Plan:
- Reset and idle:
  - Stimulus: assert i_rst_n=0 mid-packet (ch2 locked, 2 beats sent); release; drive ch0 valid, data 0x1111, last=1.
  - Required: during reset all outputs are 0. After release ch0 is granted immediately (lock was cleared) and o_data=0x1111 with o_chan=0 one cycle later.
- Round-robin fairness:
  - Stimulus: RR=1, all 4 channels continuously valid, single-beat packets, data 0xA000+k, i_ready=1.
  - Required: o_chan sequence 0,1,2,3,0,1..., one beat per cycle.
- Fixed priority:
  - Stimulus: RR=0, ch1 and ch3 valid.
  - Required: ch1 is served every cycle and ch3 starves until ch1 drops valid; ch3 is then served the next cycle.
- Packet lock:
  - Stimulus: ch2 sends 3 beats (0x2001, 0x2002, 0x2003 with last) and idles 2 cycles between beats 1 and 2; ch0 is valid throughout.
  - Required: ch0 o_ready stays 0 until ch2's last beat is accepted. o_data is contiguous 0x2001, 0x2002, 0x2003, then ch0's beat. With RR=1 the pointer becomes 3.
- Backpressure:
  - Stimulus: o_valid=1 with 0x1234, hold i_ready=0 for 5 cycles while inputs stay valid.
  - Required: o_data=0x1234 is stable, all o_ready=0, and no beat is lost. On i_ready=1 the next beat follows back-to-back.
- Wrap and width:
  - Stimulus: CHANNELS=3, WIDTH=8, RR=1; ch2 sends a last beat, then ch0 and ch1 are valid.
  - Required: ch0 is granted next (pointer wrapped 2 to 0), and o_data carries ch0's byte exactly.
